fetch_sequencer: RTL and testbench

Instruction fetch and program-sequencing stage that sits directly upstream of the datapath. It reads each 8-bit instruction as two 4-bit nibbles from program memory and drives the opcode and `inst_operand` nibbles consumed by the decoder and datapath. It also owns the 8-bit program counter and a small return-address stack. It resolves JCN/JUN/JMS/BBL control flow, using the datapath's `take_branch` for conditional jumps.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/return_stack.sv | 47 ++++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / sequencing stage.
package fetch_pkg;

  localparam int PC_W = 8;

  typedef enum logic [2:0] {
    S_FETCH_HI = 3'd0,
    S_FETCH_LO = 3'd1,
    S_ARG_HI   = 3'd2,
    S_ARG_LO   = 3'd3,
    S_EXEC     = 3'd4
  } fetch_state_e;

  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_BBL = 4'hC;

  // Opcodes followed by a second byte holding an 8-bit jump target.
  function automatic logic has_target(input logic [3:0] opr);
    return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory and decoder/datapath signals of the fetch stage.
interface fetch_sequencer_if;

  // inst_valid is a one-cycle execute strobe with no ready: the consumer must
  // act on opr/inst_operand in that cycle; the only back-pressure is halt.
  logic [3:0]                 data;
  logic                       take_branch;
  logic [fetch_pkg::PC_W-1:0] addr;
  logic                       nibble_sel;
  logic [3:0]                 opr;
  logic [3:0]                 inst_operand;
  logic                       inst_valid;

  modport master (
    input  data, take_branch,
    output addr, nibble_sel, opr, inst_operand, inst_valid
  );

  modport slave (
    output data, take_branch,
    input  addr, nibble_sel, opr, inst_operand, inst_valid
  );

endinterface

// File: rtl/return_stack.sv
// Circular return-address stack; a push onto a full stack drops the oldest entry.
module return_stack
  import fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic [1:0]      depth,
  output logic            overflow
);

  localparam logic [1:0] LAST = 2'(STACK_DEPTH - 1);
  localparam logic [1:0] FULL = 2'(STACK_DEPTH);

  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [1:0]      top_q;
  logic [1:0]      top_next;
  logic [1:0]      top_prev;

  // top_q is the next slot to write; when full it also points at the oldest entry.
  assign top_next = (top_q == LAST) ? 2'd0 : top_q + 2'd1;
  assign top_prev = (top_q == 2'd0) ? LAST : top_q - 2'd1;
  assign pop_data = (depth == 2'd0) ? '0 : mem_q[top_prev];

  always_ff @(posedge clock) begin
    if (reset) begin
      top_q    <= 2'd0;
      depth    <= 2'd0;
      overflow <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[top_q] <= push_data;
      top_q        <= top_next;
      if (depth == FULL) overflow <= 1'b1;
      else               depth    <= depth + 2'd1;
    end else if (pop && (depth != 2'd0)) begin
      top_q <= top_prev;
      depth <= depth - 2'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and program sequencing: nibble fetch FSM, program counter
// and JCN/JUN/JMS/BBL resolution.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  fetch_sequencer_if.master bus,
  output logic [1:0]        stack_depth,
  output logic              stack_overflow,
  output fetch_state_e      debug_state
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target_q, target_d;
  logic [PC_W-1:0] pc_plus1, pc_plus2, pop_data;
  logic [3:0]      opr_q, opr_d, operand_q, operand_d;
  logic            push, pop;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign pc_plus2 = pc_q + PC_W'(2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH_HI;
      pc_q      <= '0;
      target_q  <= '0;
      opr_q     <= '0;
      operand_q <= '0;
    end else if (!halt) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      opr_q     <= opr_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    opr_d     = opr_q;
    operand_d = operand_q;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_FETCH_HI: begin
        opr_d   = bus.data;
        state_d = S_FETCH_LO;
      end
      S_FETCH_LO: begin
        operand_d = bus.data;
        state_d   = has_target(opr_q) ? S_ARG_HI : S_EXEC;
      end
      S_ARG_HI: begin
        target_d[7:4] = bus.data;
        state_d       = S_ARG_LO;
      end
      S_ARG_LO: begin
        target_d[3:0] = bus.data;
        state_d       = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH_HI;
        case (opr_q)
          OPR_JUN: pc_d = target_q;
          OPR_JMS: begin
            push = 1'b1;
            pc_d = target_q;
          end
          OPR_JCN: pc_d = bus.take_branch ? target_q : pc_plus2;
          OPR_BBL: begin
            pop  = 1'b1;
            pc_d = pop_data;
          end
          default: pc_d = pc_plus1;
        endcase
      end
      default: state_d = S_FETCH_HI;
    endcase
  end

  // The target byte sits right after the opcode byte, so ARG reads from pc+1.
  assign bus.addr         = ((state_q == S_ARG_HI) || (state_q == S_ARG_LO)) ? pc_plus1 : pc_q;
  assign bus.nibble_sel   = (state_q == S_FETCH_LO) || (state_q == S_ARG_LO) || (state_q == S_EXEC);
  assign bus.inst_valid   = (state_q == S_EXEC) && !halt;
  assign bus.opr          = opr_q;
  assign bus.inst_operand = operand_q;
  assign debug_state      = state_q;

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (push && !halt),
    .pop      (pop && !halt),
    .push_data(pc_plus2),
    .pop_data (pop_data),
    .depth    (stack_depth),
    .overflow (stack_overflow)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: program memory model plus an execute scoreboard.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic halt  = 1'b0;
  logic take_branch = 1'b0;
  always #5 clock = ~clock;

  fetch_sequencer_if bus ();
  logic [1:0]   stack_depth;
  logic         stack_overflow;
  fetch_state_e debug_state;

  fetch_sequencer #(.STACK_DEPTH(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .halt          (halt),
    .bus           (bus),
    .stack_depth   (stack_depth),
    .stack_overflow(stack_overflow),
    .debug_state   (debug_state)
  );

  logic [7:0] mem [256];
  assign bus.data        = bus.nibble_sel ? mem[bus.addr][3:0] : mem[bus.addr][7:4];
  assign bus.take_branch = take_branch;

  // scoreboard: each entry is {opr, inst_operand, address of the next fetch}
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exec_count = 0;
  int last_exec_cyc = 0;
  int exec_gap = 0;
  bit pend = 1'b0;
  logic [7:0] pend_addr = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    logic [15:0] e;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("next_addr", 16'(bus.addr), 16'(pend_addr));
        check("next_nsel", 16'(bus.nibble_sel), 16'd0);
        pend = 1'b0;
      end
      if (bus.inst_valid) begin
        exec_count++;
        exec_gap      = cyc - last_exec_cyc;
        last_exec_cyc = cyc;
        check("exec_expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("exec_opr", 16'(bus.opr), 16'(e[15:12]));
          check("exec_operand", 16'(bus.inst_operand), 16'(e[11:8]));
          pend_addr = e[7:0];
          pend      = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("rst_state", 16'(debug_state), 16'(S_FETCH_HI));
    check("rst_addr", 16'(bus.addr), 16'h00);
    check("rst_nsel", 16'(bus.nibble_sel), 16'd0);
    check("rst_valid", 16'(bus.inst_valid), 16'd0);
    check("rst_opr", 16'({bus.opr, bus.inst_operand}), 16'h00);
    check("rst_depth", 16'(stack_depth), 16'd0);
    check("rst_ovf", 16'(stack_overflow), 16'd0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_exec(input int target, input int budget);
    int n = 0;
    while ((exec_count < target) && (n < budget)) begin
      @(posedge clock);
      n++;
    end
    check("exec_reached", 16'(exec_count >= target), 16'd1);
    @(negedge clock);
    #1;
  endtask

  int base;

  initial begin
    // single-byte instruction latency
    clear_mem();
    mem[8'h00] = 8'hD3;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'hD, 4'h3, 8'h01});
    @(negedge clock);
    check("c1_addr", 16'(bus.addr), 16'h00);
    check("c1_nsel", 16'(bus.nibble_sel), 16'd0);
    check("c1_state", 16'(debug_state), 16'(S_FETCH_HI));
    @(negedge clock);
    check("c2_nsel", 16'(bus.nibble_sel), 16'd1);
    check("c2_state", 16'(debug_state), 16'(S_FETCH_LO));
    @(negedge clock);
    check("c3_valid", 16'(bus.inst_valid), 16'd1);
    check("c3_state", 16'(debug_state), 16'(S_EXEC));
    wait_exec(base + 1, 20);

    // JUN 0x80 at 0x10
    clear_mem();
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h40; mem[8'h11] = 8'h80;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'h4, 4'h0, 8'h10});
    exp_q.push_back({4'h4, 4'h0, 8'h80});
    wait_exec(base + 1, 20);
    @(negedge clock);
    @(negedge clock);
    check("jun_arghi_addr", 16'(bus.addr), 16'h11);
    check("jun_arghi_nsel", 16'(bus.nibble_sel), 16'd0);
    @(negedge clock);
    check("jun_arglo_addr", 16'(bus.addr), 16'h11);
    check("jun_arglo_nsel", 16'(bus.nibble_sel), 16'd1);
    wait_exec(base + 2, 20);
    check("jun_latency", 16'(exec_gap), 16'd5);

    // JCN taken and not taken at 0x20
    for (int t = 1; t >= 0; t--) begin
      clear_mem();
      mem[8'h00] = 8'h40; mem[8'h01] = 8'h20;
      mem[8'h20] = 8'h14; mem[8'h21] = 8'h50;
      take_branch = t[0];
      do_reset();
      base = exec_count;
      exp_q.push_back({4'h4, 4'h0, 8'h20});
      exp_q.push_back({4'h1, 4'h4, (t == 1) ? 8'h50 : 8'h22});
      wait_exec(base + 2, 30);
    end
    take_branch = 1'b0;

    // JMS 0x60 from 0x30, BBL back to 0x32
    clear_mem();
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h30;
    mem[8'h30] = 8'h50; mem[8'h31] = 8'h60;
    mem[8'h60] = 8'hC0;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'h4, 4'h0, 8'h30});
    exp_q.push_back({4'h5, 4'h0, 8'h60});
    exp_q.push_back({4'hC, 4'h0, 8'h32});
    wait_exec(base + 2, 30);
    check("jms_depth", 16'(stack_depth), 16'd1);
    wait_exec(base + 3, 20);
    check("bbl_depth", 16'(stack_depth), 16'd0);

    // four nested calls overflow a 3-deep stack; the fourth BBL finds it empty
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h50; mem[8'h11] = 8'h20; mem[8'h12] = 8'hC0;
    mem[8'h20] = 8'h50; mem[8'h21] = 8'h30; mem[8'h22] = 8'hC0;
    mem[8'h30] = 8'h50; mem[8'h31] = 8'h40; mem[8'h32] = 8'hC0;
    mem[8'h40] = 8'hC0;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'h5, 4'h0, 8'h10});
    exp_q.push_back({4'h5, 4'h0, 8'h20});
    exp_q.push_back({4'h5, 4'h0, 8'h30});
    exp_q.push_back({4'h5, 4'h0, 8'h40});
    exp_q.push_back({4'hC, 4'h0, 8'h32});
    exp_q.push_back({4'hC, 4'h0, 8'h22});
    exp_q.push_back({4'hC, 4'h0, 8'h12});
    exp_q.push_back({4'hC, 4'h0, 8'h00});
    wait_exec(base + 4, 40);
    check("nest_depth", 16'(stack_depth), 16'd3);
    check("nest_ovf", 16'(stack_overflow), 16'd1);
    wait_exec(base + 8, 40);
    check("unwind_depth", 16'(stack_depth), 16'd0);
    check("unwind_ovf_sticky", 16'(stack_overflow), 16'd1);

    // pc wrap: single-byte at 0xFF, then JCN not taken at 0xFF
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[8'h00] = 8'h40; mem[8'h01] = 8'hFF;
      mem[8'hFF] = (k == 0) ? 8'h00 : 8'h10;
      do_reset();
      base = exec_count;
      exp_q.push_back({4'h4, 4'h0, 8'hFF});
      exp_q.push_back((k == 0) ? {4'h0, 4'h0, 8'h00} : {4'h1, 4'h0, 8'h01});
      wait_exec(base + 2, 30);
      if (k == 0) check("wrap_latency", 16'(exec_gap), 16'd3);
    end

    // halt held for four cycles in ARG_LO
    clear_mem();
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h10;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'h4, 4'h0, 8'h10});
    repeat (4) @(negedge clock);
    check("pre_halt_state", 16'(debug_state), 16'(S_ARG_LO));
    halt = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("halt_state", 16'(debug_state), 16'(S_ARG_LO));
      check("halt_addr", 16'(bus.addr), 16'h01);
      check("halt_nsel", 16'(bus.nibble_sel), 16'd1);
      check("halt_valid", 16'(bus.inst_valid), 16'd0);
    end
    halt = 1'b0;
    wait_exec(base + 1, 20);
    @(negedge clock);
    check("halt_single_exec", 16'(exec_count - base), 16'd1);
    check("halt_queue_empty", 16'(exp_q.size()), 16'd0);

    // reset arriving in ARG_HI abandons the instruction and empties the stack
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h40; mem[8'h11] = 8'h20;
    do_reset();
    base = exec_count;
    exp_q.push_back({4'h5, 4'h0, 8'h10});
    wait_exec(base + 1, 20);
    check("pre_rst_depth", 16'(stack_depth), 16'd1);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_state", 16'(debug_state), 16'(S_ARG_HI));
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
